fetch_cache_unit: RTL and testbench

Parametrised instruction-fetch front end: owns the program counter and a direct-mapped, multi-word-line instruction cache. On a miss it stalls the PC and refills the line from instruction memory over a req/ready handshake. Sits between the core's decode stage and the instruction memory. It replaces the delay-based miss stall with a real refill state machine, and adds reset, fetch enable, flush and miss counting.

---
 rtl/fetch_cache_unit_if.sv | 13 +
 rtl/fetch_cache_unit.sv | 129 ++++++++++++
 tb/tb_fetch_cache_unit.sv | 300 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_cache_unit_if.sv
// fetch_cache_unit_if: line refill handshake between the fetch unit and instruction memory
interface fetch_cache_unit_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int LINE_W     = 128
);
    logic                  mem_req;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic                  mem_ready;
    logic [LINE_W-1:0]     mem_line;

    modport master (output mem_req, mem_addr, input mem_ready, mem_line);
    modport slave  (input mem_req, mem_addr, output mem_ready, mem_line);
endinterface

// File: rtl/fetch_cache_unit.sv
// fetch_cache_unit: PC owner with a direct-mapped multi-word instruction cache and a line refill FSM
module fetch_cache_unit #(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    WORD_WIDTH = 32,
    parameter int                    LINE_WORDS = 4,
    parameter int                    NUM_SETS   = 16,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = 32'hA75D53D8,
    parameter int                    CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  flush,
    output logic [WORD_WIDTH-1:0] instr_out,
    output logic [ADDR_WIDTH-1:0] pc_out,
    output logic                  instr_valid,
    output logic                  hit,
    output logic [CNT_WIDTH-1:0]  miss_count,
    fetch_cache_unit_if.master    mem
);
    localparam int OFF_BITS  = $clog2(WORD_WIDTH / 8);
    localparam int WORD_BITS = $clog2(LINE_WORDS);
    localparam int IDX_BITS  = $clog2(NUM_SETS);
    localparam int LINE_BITS = OFF_BITS + WORD_BITS;
    localparam int TAG_BITS  = ADDR_WIDTH - LINE_BITS - IDX_BITS;
    localparam int LINE_W    = LINE_WORDS * WORD_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] PC_STEP = ADDR_WIDTH'(WORD_WIDTH / 8);

    typedef enum logic {LOOKUP, REQ} state_t;

    state_t                state_q, state_d;
    logic                  flush_pend_q, flush_pend_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_out_q, mem_addr_q;
    logic [WORD_WIDTH-1:0] instr_q;
    logic                  valid_out_q, hit_q;
    logic [CNT_WIDTH-1:0]  miss_q;
    logic [NUM_SETS-1:0]   valid_q;
    logic [TAG_BITS-1:0]   tag_q [NUM_SETS];
    logic [LINE_W-1:0]     data_q [NUM_SETS];

    logic [IDX_BITS-1:0]   idx;
    logic [TAG_BITS-1:0]   tag;
    logic [WORD_BITS-1:0]  wsel;
    logic [WORD_WIDTH-1:0] word;
    logic                  lookup_hit, do_hit, do_miss, do_fill, do_inv;

    assign idx        = pc_q[LINE_BITS +: IDX_BITS];
    assign tag        = pc_q[ADDR_WIDTH-1 -: TAG_BITS];
    assign wsel       = pc_q[OFF_BITS +: WORD_BITS];
    assign word       = data_q[idx][wsel * WORD_WIDTH +: WORD_WIDTH];
    assign lookup_hit = valid_q[idx] && (tag_q[idx] == tag);

    assign instr_out    = instr_q;
    assign pc_out       = pc_out_q;
    assign instr_valid  = valid_out_q;
    assign hit          = hit_q;
    assign miss_count   = miss_q;
    assign mem.mem_req  = (state_q == REQ);
    assign mem.mem_addr = mem_addr_q;

    // FSM state and the flush request remembered across a refill
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= LOOKUP;
            flush_pend_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            flush_pend_q <= flush_pend_d;
        end
    end

    // Next state and per-cycle actions; a flush anywhere in a refill discards the returning line
    always_comb begin
        state_d      = state_q;
        flush_pend_d = 1'b0;
        do_hit       = 1'b0;
        do_miss      = 1'b0;
        do_fill      = 1'b0;
        do_inv       = 1'b0;
        if (state_q == LOOKUP) begin
            do_inv  = flush;
            do_hit  = en && !flush && lookup_hit;
            do_miss = en && !do_hit;
            state_d = do_miss ? REQ : LOOKUP;
        end else if (mem.mem_ready) begin
            do_fill = !(flush_pend_q || flush);
            do_inv  = !do_fill;
            state_d = LOOKUP;
        end else begin
            flush_pend_d = flush_pend_q || flush;
        end
    end

    // PC, registered fetch outputs, refill address, miss counter and valid bits
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q        <= RESET_PC;
            instr_q     <= '0;
            pc_out_q    <= '0;
            valid_out_q <= 1'b0;
            hit_q       <= 1'b0;
            mem_addr_q  <= '0;
            miss_q      <= '0;
            valid_q     <= '0;
        end else begin
            valid_out_q <= do_hit;
            hit_q       <= do_hit;
            if (do_hit) begin
                instr_q  <= word;
                pc_out_q <= pc_q;
                pc_q     <= pc_q + PC_STEP;
            end
            if (do_miss) begin
                mem_addr_q <= {pc_q[ADDR_WIDTH-1:LINE_BITS], {LINE_BITS{1'b0}}};
                if (miss_q != '1) miss_q <= miss_q + 1'b1;
            end
            if (do_inv) valid_q <= '0;
            else if (do_fill) valid_q[idx] <= 1'b1;
        end
    end

    // Tag and line storage are written on refill only and carry no reset
    always_ff @(posedge clk) begin
        if (do_fill) begin
            tag_q[idx]  <= tag;
            data_q[idx] <= mem.mem_line;
        end
    end
endmodule

// File: tb/tb_fetch_cache_unit.sv
// tb_fetch_cache_unit: randomized scoreboard bench for two fetch_cache_unit configurations
module tb_fetch_cache_unit;
    typedef struct {
        int          cyc;
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    logic clk = 1'b0, rst_n = 1'b0, en = 1'b0, flush = 1'b0;
    logic rdy0, rdy1;
    logic [127:0] ln0, ln1;
    logic [31:0] io0, io1, po0, po1;
    logic iv0, iv1, ht0, ht1;
    logic [15:0] mc0;
    logic [1:0] mc1;
    int cyc = 0;
    int vectors = 0;
    int errors = 0;

    exp_t        oq [2][$];
    logic [31:0] aq [2][$];
    logic        preq [2];
    logic [31:0] cur_a [2];

    logic [31:0] m_pc [2];
    logic        m_wait [2];
    logic        m_fpend [2];
    int          m_wcnt [2];
    logic [15:0] m_miss [2];
    logic        m_has [2][16];
    logic [31:0] m_line [2][16];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    fetch_cache_unit_if #(.ADDR_WIDTH(32), .LINE_W(128)) m0 ();
    fetch_cache_unit_if #(.ADDR_WIDTH(32), .LINE_W(128)) m1 ();
    assign m0.mem_ready = rdy0;
    assign m0.mem_line  = ln0;
    assign m1.mem_ready = rdy1;
    assign m1.mem_line  = ln1;

    fetch_cache_unit dut0 (
        .clk(clk), .rst_n(rst_n), .en(en), .flush(flush),
        .instr_out(io0), .pc_out(po0), .instr_valid(iv0), .hit(ht0),
        .miss_count(mc0), .mem(m0.master)
    );

    fetch_cache_unit #(.RESET_PC(32'hFFFFFFFC), .CNT_WIDTH(2)) dut1 (
        .clk(clk), .rst_n(rst_n), .en(en), .flush(flush),
        .instr_out(io1), .pc_out(po1), .instr_valid(iv1), .hit(ht1),
        .miss_count(mc1), .mem(m1.master)
    );

    function automatic logic [31:0] mword(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ (a * 32'h9E3779B1) ^ 32'h5A5AC3C3;
    endfunction

    function automatic logic [127:0] line_of(input logic [31:0] a);
        logic [127:0] l;
        for (int k = 0; k < 4; k++) l[k*32 +: 32] = mword(a + 32'(k * 4));
        return l;
    endfunction

    function automatic logic cached(input int i, input logic [31:0] a);
        return m_has[i][a[7:4]] && (m_line[i][a[7:4]] == (a & 32'hFFFFFFF0));
    endfunction

    task automatic forget(input int i);
        for (int s = 0; s < 16; s++) m_has[i][s] = 1'b0;
    endtask

    task automatic reset_model();
        m_pc[0] = 32'hA75D53D8;
        m_pc[1] = 32'hFFFFFFFC;
        for (int i = 0; i < 2; i++) begin
            m_wait[i]  = 1'b0;
            m_fpend[i] = 1'b0;
            m_wcnt[i]  = 0;
            m_miss[i]  = '0;
            forget(i);
            oq[i].delete();
            aq[i].delete();
        end
    endtask

    // mode 0: memory answers at once, 1: after 5 waiting cycles, 2: random, 3: never
    task automatic step(input int mode);
        for (int i = 0; i < 2; i++) begin
            logic r;
            logic [127:0] l;
            logic [31:0] la;
            la = m_pc[i] & 32'hFFFFFFF0;
            if (m_wait[i])
                r = (mode == 0) ? 1'b1 : (mode == 1) ? (m_wcnt[i] >= 5) :
                    (mode == 2) ? ($urandom_range(0, 99) < 35) : 1'b0;
            else
                r = 1'($urandom_range(0, 1));
            l = (m_wait[i] && r) ? line_of(la) : {$urandom, $urandom, $urandom, $urandom};
            if (i == 0) begin rdy0 = r; ln0 = l; end
            else begin rdy1 = r; ln1 = l; end
            if (m_wait[i]) begin
                m_fpend[i] = m_fpend[i] | flush;
                m_wcnt[i]++;
                if (r) begin
                    if (m_fpend[i]) forget(i);
                    else begin
                        m_has[i][la[7:4]]  = 1'b1;
                        m_line[i][la[7:4]] = la;
                    end
                    m_wait[i]  = 1'b0;
                    m_fpend[i] = 1'b0;
                end
            end else begin
                if (flush) forget(i);
                if (en) begin
                    if (!flush && cached(i, m_pc[i])) begin
                        oq[i].push_back('{cyc + 1, m_pc[i], mword(m_pc[i])});
                        m_pc[i] = m_pc[i] + 32'd4;
                    end else begin
                        if (m_miss[i] != ((i == 0) ? 16'hFFFF : 16'h0003)) m_miss[i]++;
                        m_wait[i] = 1'b1;
                        m_wcnt[i] = 0;
                        aq[i].push_back(la);
                    end
                end
            end
        end
    endtask

    task automatic chk_mc();
        logic [15:0] a;
        for (int i = 0; i < 2; i++) begin
            a = (i == 0) ? mc0 : {14'b0, mc1};
            vectors++;
            if (a !== m_miss[i]) begin
                errors++;
                $display("FAIL miss_count[%0d] cyc %0d: got %0d expected %0d", i, cyc, a, m_miss[i]);
            end
        end
    endtask

    task automatic rst_chk();
        logic [133:0] a;
        for (int i = 0; i < 2; i++) begin
            a = (i == 0) ? {m0.mem_req, m0.mem_addr, iv0, ht0, po0, io0, mc0}
                         : {m1.mem_req, m1.mem_addr, iv1, ht1, po1, io1, 14'b0, mc1};
            vectors++;
            if (a !== '0) begin
                errors++;
                $display("FAIL reset_values[%0d] cyc %0d: got %h expected all zero", i, cyc, a);
            end
        end
    endtask

    task automatic mon(input int i, input logic v, input logic h, input logic rq,
                       input logic [31:0] p, input logic [31:0] ins, input logic [31:0] a);
        exp_t e;
        vectors++;
        if (h !== v) begin
            errors++;
            $display("FAIL hit_vs_valid[%0d] cyc %0d: hit=%b expected %b", i, cyc, h, v);
        end
        if (v) begin
            vectors++;
            if (oq[i].size() == 0) begin
                errors++;
                $display("FAIL unexpected_output[%0d] cyc %0d: pc_out=%h with none expected", i, cyc, p);
            end else begin
                e = oq[i].pop_front();
                if (p !== e.pc || ins !== e.instr || cyc != e.cyc) begin
                    errors++;
                    $display("FAIL fetch[%0d]: got pc=%h instr=%h cyc=%0d expected pc=%h instr=%h cyc=%0d",
                             i, p, ins, cyc, e.pc, e.instr, e.cyc);
                end
            end
        end else if (oq[i].size() != 0 && oq[i][0].cyc <= cyc) begin
            vectors++;
            errors++;
            e = oq[i].pop_front();
            $display("FAIL missing_output[%0d] cyc %0d: instr_valid=0 expected pc=%h", i, cyc, e.pc);
        end
        if (rq && !preq[i]) begin
            vectors++;
            if (aq[i].size() == 0) begin
                errors++;
                $display("FAIL unexpected_req[%0d] cyc %0d: mem_addr=%h with no miss expected", i, cyc, a);
            end else begin
                cur_a[i] = aq[i].pop_front();
                if (a !== cur_a[i]) begin
                    errors++;
                    $display("FAIL mem_addr[%0d] cyc %0d: got %h expected %h", i, cyc, a, cur_a[i]);
                end
            end
        end else if (rq) begin
            vectors++;
            if (a !== cur_a[i]) begin
                errors++;
                $display("FAIL mem_addr_stable[%0d] cyc %0d: got %h expected %h", i, cyc, a, cur_a[i]);
            end
        end
        preq[i] = rq;
    endtask

    // Monitor: every DUT output event is popped against the model's predictions
    always @(negedge clk) begin
        if (rst_n) begin
            mon(0, iv0, ht0, m0.mem_req, po0, io0, m0.mem_addr);
            mon(1, iv1, ht1, m1.mem_req, po1, io1, m1.mem_addr);
        end else begin
            preq[0] = 1'b0;
            preq[1] = 1'b0;
        end
    end

    task automatic rand_cycles(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            if (k % 64 == 0) chk_mc();
            en    = ($urandom_range(0, 99) < 85);
            flush = ($urandom_range(0, 99) < 3);
            step(2);
        end
    endtask

    initial begin
        rdy0 = 1'b0; rdy1 = 1'b0; ln0 = '0; ln1 = '0;
        reset_model();
        repeat (3) @(negedge clk);
        rst_chk();
        @(negedge clk);
        rst_n = 1'b1; en = 1'b1; flush = 1'b0;
        step(0);
        @(negedge clk);
        vectors++;
        if (m0.mem_req !== 1'b1 || m0.mem_addr !== 32'hA75D53D0) begin
            errors++;
            $display("FAIL first_req0: req=%b addr=%h expected req=1 addr=a75d53d0", m0.mem_req, m0.mem_addr);
        end
        vectors++;
        if (m1.mem_req !== 1'b1 || m1.mem_addr !== 32'hFFFFFFF0) begin
            errors++;
            $display("FAIL first_req1: req=%b addr=%h expected req=1 addr=fffffff0", m1.mem_req, m1.mem_addr);
        end
        step(0);
        repeat (4) begin @(negedge clk); step(0); end
        @(negedge clk);
        vectors++;
        if (mc0 !== 16'd2) begin
            errors++;
            $display("FAIL cold_miss_count: got %0d expected 2", mc0);
        end
        chk_mc();
        step(0);
        for (int k = 0; k < 60; k++) begin @(negedge clk); step(1); end
        @(negedge clk);
        chk_mc();
        step(1);
        rand_cycles(3000);
        en = 1'b1; flush = 1'b0;
        for (int k = 0; k < 100 && !m_wait[0]; k++) begin @(negedge clk); step(3); end
        @(negedge clk);
        #2;
        vectors++;
        if (m0.mem_req !== 1'b1) begin
            errors++;
            $display("FAIL req_before_reset: mem_req=%b expected 1", m0.mem_req);
        end
        for (int i = 0; i < 2; i++) begin
            vectors++;
            if (oq[i].size() != 0) begin
                errors++;
                $display("FAIL pending_before_reset[%0d]: %0d outputs outstanding expected 0", i, oq[i].size());
            end
        end
        rst_n = 1'b0;
        #1;
        rst_chk();
        reset_model();
        en = 1'b0; flush = 1'b0; rdy0 = 1'b0; rdy1 = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1; en = 1'b1;
        step(2);
        rand_cycles(300);
        en = 1'b0; flush = 1'b0;
        repeat (12) begin @(negedge clk); step(0); end
        @(negedge clk);
        chk_mc();
        for (int i = 0; i < 2; i++) begin
            vectors++;
            if (oq[i].size() != 0 || aq[i].size() != 0) begin
                errors++;
                $display("FAIL drain[%0d]: %0d outputs and %0d requests outstanding expected 0",
                         i, oq[i].size(), aq[i].size());
            end
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
